// File: rtl/wl_bitser_pkg.sv
// Shared types and sizing helpers for the word-line bit-serialiser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wl_bitser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WL_N_ROW_DEF    = 8;
    localparam int WL_DW_DEF       = 6;
    localparam int WL_SIGN_IDX_DEF = WL_DW_DEF - 1;

    // Width of a slice index; never zero so DW=1 still gets a real port.
    function automatic int bidx_w(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/wl_shift_lane.sv
// One activation row: loadable right-shift register with optional ReLU clamp on load.
// Latency: load/shift take effect on the next clock; bit0 is a register output.
// Backpressure: holds its value whenever neither load nor shift is asserted.
module wl_shift_lane
    import wl_bitser_pkg::*;
#(
    parameter int DW = WL_DW_DEF,
    parameter int SW = bidx_w(DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          shift,
    input  logic          relu,
    input  logic [DW-1:0] din,
    input  logic [SW-1:0] ld_sh,
    input  logic [SW-1:0] sh,
    output logic          bit0
);

    logic [DW-1:0] q;
    logic [DW-1:0] clamped;

    assign clamped = (relu && din[DW-1]) ? '0 : din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= clamped >> ld_sh;
        end else if (shift) begin
            q <= q >> sh;
        end
    end

    assign bit0 = q[0];

endmodule

// File: rtl/wl_bitser.sv
// Bit-serialises a vector of signed activations into LSB-first word-line slices; optional WL_BITSER_ZERO_SKIP_EN drops all-zero slices.
// Latency: first slice one cycle after capture; DW slices per vector (1..DW with zero-skip), no bubble back-to-back.
// Backpressure: out_ready=0 freezes the current slice; in_ready only opens in IDLE or on the accepted last slice.
module wl_bitser
    import wl_bitser_pkg::*;
#(
    parameter int N_ROW = WL_N_ROW_DEF,
    parameter int DW    = WL_DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_ROW*DW-1:0]    in_data,
    input  logic                   in_relu,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_ROW-1:0]       wl,
    output logic [bidx_w(DW)-1:0]  bit_idx,
    output logic                   bit_neg,
    output logic                   frame_first,
    output logic                   frame_last
);

    localparam int              BW       = bidx_w(DW);
    localparam int              SIGN_IDX = DW - 1;
    localparam logic [BW-1:0]   SIGN_B   = BW'(SIGN_IDX);

    state_t          state;
    state_t          state_nxt;
    logic            alive;
    logic            cap;
    logic            adv;
    logic            last;
    logic            first_q;
    logic [BW-1:0]   idx_q;
    logic [BW-1:0]   first_idx;
    logic [BW-1:0]   nxt_idx;
    logic [BW-1:0]   ld_amt;
    logic [BW-1:0]   sh_amt;
    logic [N_ROW-1:0] lane_bit;

    // Goes high on the first clock after reset release so in_ready is registered out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
        end
    end

    assign adv      = (state == SHIFT) && out_ready;
    assign in_ready = alive && ((state == IDLE) || (last && adv));
    assign cap      = in_valid && in_ready;

`ifdef WL_BITSER_ZERO_SKIP_EN
    logic [DW-1:0] occ;
    logic [DW-1:0] mask_q;

    // Column occupancy of the post-clamp vector: bit k set if any row has bit k set.
    always_comb begin
        occ = '0;
        for (int r = 0; r < N_ROW; r++) begin
            if (!(in_relu && in_data[r*DW + DW - 1])) begin
                occ = occ | in_data[r*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (cap) begin
            mask_q <= occ;
        end
    end

    always_comb begin
        first_idx = '0;
        nxt_idx   = idx_q;
        last      = 1'b1;
        for (int k = DW - 1; k >= 0; k--) begin
            if (occ[k]) begin
                first_idx = BW'(k);
            end
            if (mask_q[k] && (k > int'(idx_q))) begin
                nxt_idx = BW'(k);
                last    = 1'b0;
            end
        end
        ld_amt = first_idx;
        sh_amt = nxt_idx - idx_q;
    end
`else
    always_comb begin
        first_idx = '0;
        nxt_idx   = idx_q + BW'(1);
        last      = (idx_q == SIGN_B);
        ld_amt    = '0;
        sh_amt    = BW'(1);
    end
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cap) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (adv && last) begin
                    state_nxt = cap ? SHIFT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slice counter and first-slice marker; a capture always restarts the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            first_q <= 1'b0;
        end else if (cap) begin
            idx_q   <= first_idx;
            first_q <= 1'b1;
        end else if (adv) begin
            first_q <= 1'b0;
            if (!last) begin
                idx_q <= nxt_idx;
            end
        end
    end

    for (genvar r = 0; r < N_ROW; r++) begin : g_lane
        wl_shift_lane #(
            .DW (DW),
            .SW (BW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (cap),
            .shift (adv && !last),
            .relu  (in_relu),
            .din   (in_data[r*DW +: DW]),
            .ld_sh (ld_amt),
            .sh    (sh_amt),
            .bit0  (lane_bit[r])
        );
    end

    // FSM: outputs, forced to zero outside SHIFT
    always_comb begin
        out_valid   = 1'b0;
        wl          = '0;
        bit_idx     = '0;
        bit_neg     = 1'b0;
        frame_first = 1'b0;
        frame_last  = 1'b0;
        if (state == SHIFT) begin
            out_valid   = 1'b1;
            wl          = lane_bit;
            bit_idx     = idx_q;
            bit_neg     = (idx_q == SIGN_B);
            frame_first = first_q;
            frame_last  = last;
        end
    end

endmodule

// File: tb/tb_wl_bitser.sv
// Randomised and directed bench for wl_bitser against a slice-list reference model.
module tb_wl_bitser;

    localparam int N_ROW = 8;
    localparam int DW    = 6;
    localparam int BW    = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_ROW*DW-1:0]   in_data;
    logic                  in_relu;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_ROW-1:0]      wl;
    logic [BW-1:0]         bit_idx;
    logic                  bit_neg;
    logic                  frame_first;
    logic                  frame_last;

    wl_bitser #(.N_ROW(N_ROW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_relu     (in_relu),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .wl          (wl),
        .bit_idx     (bit_idx),
        .bit_neg     (bit_neg),
        .frame_first (frame_first),
        .frame_last  (frame_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_ROW-1:0] wl;
        int               idx;
        bit               first;
        bit               last;
    } slice_t;

    slice_t           exp_q[$];
    int               frm_q[$];
    int               ff_pos[$];
    int               recon[N_ROW];
    int               n_cmp = 0;
    int               n_err = 0;
    int               acc_cnt = 0;
    int               ov_cnt = 0;
    int               pi = 0;
    bit [3:0]         pat = 4'b1001;
    bit               last_cap;
    bit               stalled = 1'b0;
    logic [N_ROW-1:0] h_wl;
    logic [BW-1:0]    h_idx;
    logic             h_first;
    logic             h_last;
    logic [N_ROW-1:0] last_wl;
    int               basic[N_ROW] = '{1, 2, 3, -1, 0, 31, -32, 5};
    int               fours[N_ROW] = '{4, 4, 4, 4, 4, 4, 4, 4};
    int               zeros[N_ROW] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int               pat15[N_ROW] = '{21, 21, 21, 21, 21, 21, 21, 21};

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N_ROW*DW-1:0] pack_rows(input int rows[N_ROW]);
        logic [N_ROW*DW-1:0] p;
        p = '0;
        for (int r = 0; r < N_ROW; r++) p[r*DW +: DW] = rows[r][DW-1:0];
        return p;
    endfunction

    // Expected slices of one vector: slice k carries bit k of every (clamped) row.
    task automatic push_frame(input logic [N_ROW*DW-1:0] d, input bit relu);
        int                 v[N_ROW];
        int                 ks[$];
        logic [N_ROW-1:0]   w[DW];
        logic signed [DW-1:0] f;
        slice_t             s;
        for (int r = 0; r < N_ROW; r++) begin
            f    = d[r*DW +: DW];
            v[r] = f;
            if (relu && v[r] < 0) v[r] = 0;
            frm_q.push_back(v[r]);
        end
        for (int k = 0; k < DW; k++) begin
            for (int r = 0; r < N_ROW; r++) w[k][r] = v[r][k];
`ifdef WL_BITSER_ZERO_SKIP_EN
            if (w[k] != '0) ks.push_back(k);
`else
            ks.push_back(k);
`endif
        end
        if (ks.size() == 0) begin
            s.wl = '0; s.idx = 0; s.first = 1'b1; s.last = 1'b1;
            exp_q.push_back(s);
        end
        for (int i = 0; i < ks.size(); i++) begin
            s.wl    = w[ks[i]];
            s.idx   = ks[i];
            s.first = (i == 0);
            s.last  = (i == ks.size() - 1);
            exp_q.push_back(s);
        end
    endtask

    // One clock: sample outputs mid-cycle, score handshakes, then advance past the edge.
    task automatic cycle();
        slice_t s;
        #1;
        chk("out_valid", out_valid, exp_q.size() > 0);
        chk("in_ready", in_ready, (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready));
        if (out_valid) begin
            ov_cnt++;
            if (frame_first) ff_pos.push_back(ov_cnt);
        end
        if (stalled && out_valid) begin
            chk("stall_wl", wl, h_wl);
            chk("stall_idx", bit_idx, h_idx);
            chk("stall_first", frame_first, h_first);
            chk("stall_last", frame_last, h_last);
        end
        stalled = out_valid && !out_ready;
        h_wl = wl; h_idx = bit_idx; h_first = frame_first; h_last = frame_last;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_slice", out_valid, 1'b0);
            end else begin
                s = exp_q.pop_front();
                acc_cnt++;
                last_wl = wl;
                chk("wl", wl, s.wl);
                chk("bit_idx", bit_idx, s.idx);
                chk("bit_neg", bit_neg, s.idx == DW - 1);
                chk("frame_first", frame_first, s.first);
                chk("frame_last", frame_last, s.last);
                if (s.first) foreach (recon[r]) recon[r] = 0;
                for (int r = 0; r < N_ROW; r++)
                    if (wl[r]) recon[r] += (s.idx == DW - 1) ? -(1 << s.idx) : (1 << s.idx);
                if (s.last)
                    for (int r = 0; r < N_ROW; r++) chk("recon", recon[r], frm_q.pop_front());
            end
        end
        last_cap = in_valid && in_ready;
        if (last_cap) push_frame(in_data, in_relu);
        @(posedge clk);
        #2;
    endtask

    task automatic drive_rdy(input int mode);
        case (mode)
            0: out_ready = 1'b1;
            1: begin out_ready = pat[pi % 4]; pi++; end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic send(input logic [N_ROW*DW-1:0] d, input bit relu, input int mode);
        in_data  = d;
        in_relu  = relu;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            drive_rdy(mode);
            cycle();
            if (last_cap) break;
        end
        if (!last_cap) chk("send_timeout", last_cap, 1'b1);
        in_valid = 1'b0;
        in_relu  = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom};
    endtask

    task automatic drain(input int mode);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            drive_rdy(mode);
            cycle();
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int a0;
        logic [N_ROW*DW-1:0] rv;
        rst_n = 1'b0; in_valid = 1'b0; in_relu = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_wl", wl, 0);
        chk("rst_bit_idx", bit_idx, 0);
        chk("rst_bit_neg", bit_neg, 1'b0);
        chk("rst_first", frame_first, 1'b0);
        chk("rst_last", frame_last, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // basic serialisation and the sign slice
        send(pack_rows(basic), 1'b0, 0);
        drain(0);
        chk("slice5_wl", last_wl, 8'b0100_1000);

        // ReLU clamp
        send(pack_rows(basic), 1'b1, 0);
        drain(0);

        // backpressure 1,0,0,1,...
        pi = 0;
        send(pack_rows(basic), 1'b0, 1);
        drain(1);

        // back-to-back: no bubble, frame_first on cycles 1 and 7
        ov_cnt = 0;
        ff_pos.delete();
        send(pack_rows(basic), 1'b0, 0);
        send(pack_rows(fours), 1'b0, 0);
        drain(0);
        chk("b2b_valid_cycles", ov_cnt, 2 * DW);
        chk("b2b_first_count", ff_pos.size(), 2);
        if (ff_pos.size() >= 2) begin
            chk("b2b_first_pos0", ff_pos[0], 1);
            chk("b2b_first_pos1", ff_pos[1], DW + 1);
        end

        // sparse vectors
        a0 = acc_cnt;
        send(pack_rows(fours), 1'b0, 0);
        drain(0);
`ifdef WL_BITSER_ZERO_SKIP_EN
        chk("zs_fours_slices", acc_cnt - a0, 1);
`else
        chk("fours_slices", acc_cnt - a0, DW);
`endif
        a0 = acc_cnt;
        send(pack_rows(zeros), 1'b1, 0);
        drain(0);
`ifdef WL_BITSER_ZERO_SKIP_EN
        chk("zs_zero_slices", acc_cnt - a0, 1);
`else
        chk("zero_slices", acc_cnt - a0, DW);
`endif

        // randomised traffic
        for (int t = 0; t < 40; t++) begin
            rv = {$urandom, $urandom};
            send(rv, 1'($urandom_range(0, 1)), 2);
            if ($urandom_range(0, 1) == 1) drain(2);
        end
        drain(2);

        // reset in the middle of a frame
        send(pack_rows(pat15), 1'b0, 0);
        a0 = acc_cnt;
        for (int i = 0; i < 20; i++) begin
            if (acc_cnt >= a0 + 2) break;
            drive_rdy(0);
            cycle();
        end
        chk("mid_slices_before_reset", acc_cnt - a0, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_wl", wl, 0);
        chk("mid_rst_bit_idx", bit_idx, 0);
        chk("mid_rst_first", frame_first, 1'b0);
        chk("mid_rst_last", frame_last, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        exp_q.delete();
        frm_q.delete();
        stalled = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        for (int i = 0; i < 10; i++) begin
            drive_rdy(0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
